// File: rtl/softmax_sum_buf.sv
`default_nettype none
// ============================================================================
// Module   : softmax_sum_buf
// Function : Softmax denominator stage. Captures one vector of VEC_LEN exp
//            results into a register buffer while accumulating their sum,
//            then replays every element paired with the final sum under a
//            valid/ready handshake.
// Options  : SOFTMAX_SUM_CLAMP_EN - negative accepted inputs become 0 before
//            storage and summation.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_sum_buf #(
  parameter int DATA_WIDTH = 41,
  parameter int VEC_LEN    = 16,
  parameter int SUM_WIDTH  = 45
) (
  input  logic                  clk_p,
  input  logic                  rst_p,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_valid_n,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SUM_WIDTH-1:0]  out_sum,
  output logic                  out_valid_n,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  err_drop
);

  localparam int                 c_ptr_w    = $clog2(VEC_LEN);
  localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(VEC_LEN - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

  localparam logic [0:0] c_st_fill  = 1'b0;
  localparam logic [0:0] c_st_drain = 1'b1;

  logic [0:0]                   r_state;
  logic [c_ptr_w-1:0]           r_wr_ptr;
  logic [c_ptr_w-1:0]           r_rd_ptr;
  logic [SUM_WIDTH-1:0]         r_sum;
  logic                         r_err_drop;
  logic [DATA_WIDTH-1:0]        r_buf [VEC_LEN];

  logic                         w_in_fill;
  logic                         w_accept;
  logic                         w_drop;
  logic                         w_xfer;
  logic signed [DATA_WIDTH-1:0] w_elem;
  logic signed [SUM_WIDTH-1:0]  w_elem_ext;

  // Handshake decode: in_ready depends on state only, never on exp_valid_n.
  assign w_in_fill = (r_state == c_st_fill);
  assign w_accept  = w_in_fill && !exp_valid_n;
  assign w_drop    = !w_in_fill && !exp_valid_n;
  assign w_xfer    = !w_in_fill && out_ready;

`ifdef SOFTMAX_SUM_CLAMP_EN
  // Negative exp results are treated as zero so the softmax stays non-negative.
  assign w_elem = exp_data[DATA_WIDTH-1] ? '0 : exp_data;
`else
  assign w_elem = exp_data;
`endif

  // Sized cast of a signed value sign-extends (or wraps for a narrow sum).
  assign w_elem_ext = SUM_WIDTH'(w_elem);

  // FSM, pointers and accumulator.
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      r_state  <= c_st_fill;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sum    <= '0;
    end else begin
      case (r_state)
        c_st_fill: begin
          if (w_accept) begin
            r_sum    <= r_sum + w_elem_ext;
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (r_wr_ptr == c_last_idx) begin
              r_state <= c_st_drain;
            end
          end
        end
        c_st_drain: begin
          if (w_xfer) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
            if (r_rd_ptr == c_last_idx) begin
              r_sum   <= '0;
              r_state <= c_st_fill;
            end
          end
        end
        default: r_state <= c_st_fill;
      endcase
    end
  end

  // Sticky drop flag: any input offered while not ready, cleared only by reset.
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      r_err_drop <= 1'b0;
    end else if (w_drop) begin
      r_err_drop <= 1'b1;
    end
  end

  // Element buffer; contents deliberately survive reset.
  always_ff @(posedge clk_p) begin
    if (w_accept && !rst_p) begin
      r_buf[r_wr_ptr] <= w_elem;
    end
  end

  // Output drive: zeros outside the replay phase.
  always_comb begin
    in_ready    = w_in_fill;
    out_valid_n = w_in_fill;
    out_data    = '0;
    out_sum     = '0;
    out_first   = 1'b0;
    out_last    = 1'b0;
    if (!w_in_fill) begin
      out_data  = r_buf[r_rd_ptr];
      out_sum   = r_sum;
      out_first = (r_rd_ptr == '0);
      out_last  = (r_rd_ptr == c_last_idx);
    end
    err_drop = r_err_drop;
  end

endmodule
`default_nettype wire

// File: tb/tb_softmax_sum_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_sum_buf
// Function : Directed self-checking bench. Instance A uses VEC_LEN=4 for the
//            functional vectors; instance B uses default widths for the
//            large-magnitude sum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_sum_buf;

  logic clk = 1'b0;
  logic rst_p;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: 4-element vectors
  logic [40:0] a_exp_data;
  logic        a_exp_valid_n;
  logic        a_in_ready;
  logic [40:0] a_out_data;
  logic [42:0] a_out_sum;
  logic        a_out_valid_n;
  logic        a_out_ready;
  logic        a_out_first;
  logic        a_out_last;
  logic        a_err_drop;

  softmax_sum_buf #(.DATA_WIDTH(41), .VEC_LEN(4), .SUM_WIDTH(43)) u_dut_a (
    .clk_p(clk), .rst_p(rst_p),
    .exp_data(a_exp_data), .exp_valid_n(a_exp_valid_n), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_sum(a_out_sum), .out_valid_n(a_out_valid_n),
    .out_ready(a_out_ready), .out_first(a_out_first), .out_last(a_out_last),
    .err_drop(a_err_drop)
  );

  // Instance B: default widths
  logic [40:0] b_exp_data;
  logic        b_exp_valid_n;
  logic        b_in_ready;
  logic [40:0] b_out_data;
  logic [44:0] b_out_sum;
  logic        b_out_valid_n;
  logic        b_out_ready;
  logic        b_out_first;
  logic        b_out_last;
  logic        b_err_drop;

  softmax_sum_buf u_dut_b (
    .clk_p(clk), .rst_p(rst_p),
    .exp_data(b_exp_data), .exp_valid_n(b_exp_valid_n), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sum(b_out_sum), .out_valid_n(b_out_valid_n),
    .out_ready(b_out_ready), .out_first(b_out_first), .out_last(b_out_last),
    .err_drop(b_err_drop)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check_eq({tag, "_in_ready"},  64'(a_in_ready),    64'd1);
    check_eq({tag, "_valid_n"},   64'(a_out_valid_n), 64'd1);
    check_eq({tag, "_data0"},     64'(a_out_data),    64'd0);
    check_eq({tag, "_sum0"},      64'(a_out_sum),     64'd0);
    check_eq({tag, "_first0"},    64'(a_out_first),   64'd0);
    check_eq({tag, "_last0"},     64'(a_out_last),    64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_p = 1'b1;
    a_exp_valid_n = 1'b1;
    b_exp_valid_n = 1'b1;
    @(negedge clk);
    rst_p = 1'b0;
  endtask

  task automatic fill_a(input logic [3:0][40:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("a_fill_in_ready", 64'(a_in_ready), 64'd1);
      a_exp_valid_n = 1'b0;
      a_exp_data    = v[i];
    end
  endtask

  // Replays one vector from A; toggle drives out_ready 1,0,1,0..., inject
  // offers an input during the second drain cycle.
  task automatic drain_a(input logic [3:0][40:0] v, input logic [42:0] s,
                         input logic toggle, input logic inject);
    int idx = 0;
    int cyc = 0;
    while (idx < 4 && cyc < 20) begin
      @(negedge clk);
      a_out_ready   = toggle ? (cyc % 2 == 0) : 1'b1;
      a_exp_valid_n = !(inject && cyc == 1);
      a_exp_data    = 41'd999;
      check_eq("a_valid_n",  64'(a_out_valid_n), 64'd0);
      check_eq("a_in_ready_drain", 64'(a_in_ready), 64'd0);
      check_eq("a_data",     64'(a_out_data),    64'(v[idx]));
      check_eq("a_sum",      64'(a_out_sum),     64'(s));
      check_eq("a_first",    64'(a_out_first),   64'(idx == 0));
      check_eq("a_last",     64'(a_out_last),    64'(idx == 3));
      if (a_out_ready) idx++;
      cyc++;
    end
    if (idx < 4) check_eq("a_drain_timeout", 64'(idx), 64'd4);
    @(negedge clk);
    a_out_ready   = 1'b0;
    a_exp_valid_n = 1'b1;
    check_idle_a("a_after");
  endtask

  initial begin
    logic [3:0][40:0] v;
    logic [40:0]      big;
    logic [40:0]      m3;

    rst_p = 1'b1;
    a_exp_data = '0; a_exp_valid_n = 1'b1; a_out_ready = 1'b0;
    b_exp_data = '0; b_exp_valid_n = 1'b1; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_p = 1'b0;

    // Reset state
    check_idle_a("rst");
    check_eq("rst_err_drop", 64'(a_err_drop), 64'd0);
    check_eq("b_rst_valid_n", 64'(b_out_valid_n), 64'd1);

    // Basic vector, out_ready held high
    v = {41'd40, 41'd30, 41'd20, 41'd10};
    fill_a(v, 4);
    drain_a(v, 43'd100, 1'b0, 1'b0);

    // Same vector with out_ready toggling
    fill_a(v, 4);
    drain_a(v, 43'd100, 1'b1, 1'b0);
    check_eq("no_drop_err", 64'(a_err_drop), 64'd0);

    // Input offered during drain: dropped, flag sticky
    fill_a(v, 4);
    drain_a(v, 43'd100, 1'b0, 1'b1);
    check_eq("drop_err_set", 64'(a_err_drop), 64'd1);
    v = {41'd4, 41'd3, 41'd2, 41'd1};
    fill_a(v, 4);
    drain_a(v, 43'd10, 1'b0, 1'b0);
    check_eq("drop_err_sticky", 64'(a_err_drop), 64'd1);

    // Reset mid-fill discards the partial vector and clears the flag
    v = {41'd0, 41'd0, 41'd7, 41'd5};
    fill_a(v, 2);
    do_reset();
    check_idle_a("mid_rst");
    check_eq("mid_rst_err_drop", 64'(a_err_drop), 64'd0);
    v = {41'd1, 41'd1, 41'd1, 41'd1};
    fill_a(v, 4);
    drain_a(v, 43'd4, 1'b0, 1'b0);

    // Negative input
    m3 = -41'sd3;
    v = {41'd1, 41'd1, 41'd1, m3};
    fill_a(v, 4);
`ifdef SOFTMAX_SUM_CLAMP_EN
    v = {41'd1, 41'd1, 41'd1, 41'd0};
    drain_a(v, 43'd3, 1'b0, 1'b0);
`else
    drain_a(v, 43'd0, 1'b0, 1'b0);
`endif

    // Default widths: 16 x (2^39-1) with no wrap
    big = 41'((64'd1 << 39) - 64'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b_exp_valid_n = 1'b0;
      b_exp_data    = big;
    end
    @(negedge clk);
    b_exp_valid_n = 1'b1;
    b_out_ready   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("b_valid_n", 64'(b_out_valid_n), 64'd0);
      check_eq("b_data",    64'(b_out_data),    64'(big));
      check_eq("b_sum",     64'(b_out_sum),     (64'd1 << 43) - 64'd16);
      check_eq("b_first",   64'(b_out_first),   64'(i == 0));
      check_eq("b_last",    64'(b_out_last),    64'(i == 15));
      @(negedge clk);
    end
    b_out_ready = 1'b0;
    check_eq("b_after_in_ready", 64'(b_in_ready), 64'd1);
    check_eq("b_after_valid_n",  64'(b_out_valid_n), 64'd1);
    check_eq("b_err_drop",       64'(b_err_drop), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/softmax_sum_buf.md
# softmax_sum_buf

Softmax denominator stage placed directly downstream of the NN-LUT exponent unit. Captures one vector of VEC_LEN exp results, stores them in a register buffer and accumulates their sum. Once the vector is complete it replays every element, paired with the final sum, to the divider stage under a valid/ready handshake.

## Interface
- DATA_WIDTH, 41: width of signed exp result from the LUT stage
- VEC_LEN, 16: elements per softmax vector (power of two, ≥2)
- SUM_WIDTH, 45: accumulator width, DATA_WIDTH + log2(VEC_LEN)
- clk_p  input  1  single clock, rising edge
- rst_p  input  1  synchronous reset, active-high
- exp_data  input  DATA_WIDTH  signed exp result
- exp_valid_n  input  1  active-low valid for exp_data
- in_ready  output  1  high while the block accepts input (FILL state)
- out_data  output  DATA_WIDTH  signed buffered element
- out_sum  output  SUM_WIDTH  signed sum of the whole vector
- out_valid_n  output  1  active-low valid for out_data/out_sum/out_first/out_last
- out_ready  input  1  active-high, downstream accepts the current output
- out_first  output  1  marks element 0 of the replay
- out_last  output  1  marks element VEC_LEN-1 of the replay
- err_drop  output  1  sticky flag: an input arrived while in_ready was low

## Operation
- Two-state FSM: FILL, DRAIN. Reset state is FILL.
- FILL:
  - in_ready=1.
  - An input is accepted on an edge where exp_valid_n=0.
  - Accept writes buf[wr_ptr], adds the element (sign-extended to SUM_WIDTH) to sum and increments wr_ptr.
  - Accepting element VEC_LEN-1 moves the FSM to DRAIN on the same edge. wr_ptr wraps to 0 and the final sum is registered.
- DRAIN:
  - in_ready=0, out_valid_n=0.
  - out_data=buf[rd_ptr], out_sum=sum (held constant).
  - out_first=(rd_ptr==0), out_last=(rd_ptr==VEC_LEN-1).
  - Transfer happens on an edge with out_ready=1; rd_ptr then increments.
  - Transfer of the last element: rd_ptr wraps to 0, sum clears to 0, FSM returns to FILL.
- Outside DRAIN: out_valid_n=1, out_first=0, out_last=0; out_data and out_sum are don't-care but driven 0.
- Dropped input (exp_valid_n=0 while in_ready=0):
  - Data is discarded; buffer, sum and pointers are unchanged.
  - err_drop is set and stays 1 until reset.
- Arithmetic:
  - Sum is two's complement and cannot overflow at the default widths.
  - No saturation; with a narrower SUM_WIDTH the sum wraps.
- Reset (synchronous, rst_p=1 at an edge), from any state including mid-FILL or mid-DRAIN:
  - FILL, wr_ptr=0, rd_ptr=0, sum=0, err_drop=0.
  - Buffer contents are not cleared.
  - A partial vector is discarded.

## Timing
- Reset values: in_ready=1 (FILL), out_valid_n=1, out_data=0, out_sum=0, out_first=0, out_last=0, err_drop=0.
- Accept: combinational on in_ready and exp_valid_n; buffer and sum update at the same edge.
- Latency: the last element is accepted at edge E. out_valid_n falls in the cycle after E, presenting element 0 and the full sum.
- Throughput with out_ready held 1: one element per cycle. A vector needs VEC_LEN fill cycles plus VEC_LEN drain cycles.
- Back-to-back: the cycle after the last drain transfer, in_ready=1 and a new element can be accepted.
- out_ready low in DRAIN: all outputs hold, with no timeout.
- in_ready is combinational from state only, with no path from exp_valid_n.

## Configuration
- SOFTMAX_SUM_CLAMP_EN defined:
  - An accepted exp_data with MSB=1 is replaced by 0 before storage and summation.
  - out_data and out_sum are therefore always ≥0.
- Not defined: negative values are stored and summed unchanged, sign-extended.

## Test plan
- VEC_LEN=4; inputs 10, 20, 30, 40 on consecutive cycles, out_ready=1 -> out_data 10, 20, 30, 40 on four consecutive cycles, out_sum=100 on all four, out_first on 10, out_last on 40, then in_ready=1.
- Same vector with out_ready toggling 1,0,1,0 -> each element held during ready-low cycles, no element lost or duplicated, sum stays 100.
- Input pulse during DRAIN -> err_drop=1 and stays 1, replayed data unchanged, next vector sums correctly.
- Reset after 2 of 4 inputs (5, 7), then vector 1, 1, 1, 1 -> out_sum=4, not 16.
- Input -3 (two's complement) in the vector -3, 1, 1, 1 -> with SOFTMAX_SUM_CLAMP_EN out_data 0 and out_sum=3; without it out_data -3 and out_sum=0.
- Default widths, 16 inputs of 2^39-1 -> out_sum=16·(2^39-1), no wrap.
